// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: sequencer states, access sizes,
// requester ownership and the common one-bit flag constants.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_state_e;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_LSB = 1'b1
    } owner_e;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic VALID   = 1'b1;
    localparam logic NULL    = 1'b0;

    // Encoding 11 is treated as a word access.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  size_bytes = 3'd1;
            SIZE_H:  size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_sequencer.sv
// Drives the byte-wide RAM port for one 1/2/4-byte access at a time,
// reassembling read bytes little-endian and generating the done cycle.
module mem_byte_sequencer
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  abort,
    input  logic                  start,
    input  logic                  start_we,
    input  logic [1:0]            start_size,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [DATA_WIDTH-1:0] start_wdata,
    input  logic [7:0]            mem_din,
    output logic                  idle,
    output logic                  done,
    output logic                  fin_read,
    output logic [DATA_WIDTH-1:0] rdata_next,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [7:0]            mem_dout,
    output logic                  mem_wr
);

    mem_state_e            state;
    logic [2:0]            cnt;
    logic [2:0]            len;
    logic [ADDR_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] wbuf;
    logic [DATA_WIDTH-1:0] rbuf;
    logic                  byte_held;
    logic                  wr_q;

    logic [2:0] cnt_nx;
    logic [2:0] last;
    logic [1:0] cap_idx;
    logic       in_cap;
    logic       at_last;
    logic       accept;

    always_comb begin
        cnt_nx   = cnt + 3'd1;
        last     = (state == MEM_WRITE) ? len : len + 3'd1;
        cap_idx  = cnt[1:0] - 2'd1;
        in_cap   = (state == MEM_READ) && (cnt != 3'd0) && (cnt <= len);
        at_last  = (state != MEM_IDLE) && (cnt == last);
        accept   = start && ((state == MEM_IDLE) || at_last);
        fin_read = en && !abort && (state == MEM_READ) && (cnt == len);
    end

    // The final byte normally comes straight off mem_din; if a stall froze the
    // sequencer on that byte it was already parked in rbuf.
    always_comb begin
        rdata_next = rbuf;
        if (!byte_held)
            rdata_next[{cap_idx, 3'b000} +: 8] = mem_din;
    end

    // A read byte is captured on the first edge it is valid, even when that
    // edge is frozen; byte_held stops the repeated-address byte overwriting it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MEM_IDLE;
            cnt       <= 3'd0;
            len       <= 3'd0;
            base      <= '0;
            wbuf      <= '0;
            rbuf      <= '0;
            byte_held <= DISABLE;
            wr_q      <= DISABLE;
            done      <= DISABLE;
            mem_a     <= '0;
            mem_dout  <= 8'h00;
        end else begin
            if (in_cap && !byte_held)
                rbuf[{cap_idx, 3'b000} +: 8] <= mem_din;
            byte_held <= in_cap && !en;
            if (en) begin
                if (accept) begin
                    state    <= start_we ? MEM_WRITE : MEM_READ;
                    cnt      <= 3'd0;
                    len      <= size_bytes(start_size);
                    base     <= start_addr;
                    wbuf     <= start_wdata;
                    rbuf     <= '0;
                    mem_a    <= start_addr;
                    mem_dout <= start_wdata[7:0];
                    wr_q     <= start_we;
                    done     <= DISABLE;
                end else if (((state == MEM_READ) && abort) || at_last) begin
                    state <= MEM_IDLE;
                    cnt   <= 3'd0;
                    mem_a <= '0;
                    wr_q  <= DISABLE;
                    done  <= DISABLE;
                end else if (state != MEM_IDLE) begin
                    cnt      <= cnt_nx;
                    mem_a    <= (cnt_nx < len) ? base + ADDR_WIDTH'(cnt_nx) : '0;
                    mem_dout <= wbuf[{cnt_nx[1:0], 3'b000} +: 8];
                    wr_q     <= (state == MEM_WRITE) && (cnt_nx < len);
                    done     <= (cnt_nx == last);
                end
            end
        end
    end

    assign idle   = (state == MEM_IDLE);
    assign mem_wr = wr_q && en;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and the
// load/store buffer, applying the pipeline freeze and flush policy.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  clear,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [DATA_WIDTH-1:0] if_data,
    input  logic                  lsb_req,
    input  logic                  lsb_we,
    input  logic [1:0]            lsb_size,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [DATA_WIDTH-1:0] lsb_wdata,
    output logic                  lsb_done,
    output logic [DATA_WIDTH-1:0] lsb_rdata,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr
);

    owner_e                owner;
    owner_e                last_owner;
    logic                  seq_idle;
    logic                  seq_done;
    logic                  fin_read;
    logic [DATA_WIDTH-1:0] rdata_next;
    logic                  if_cand;
    logic                  lsb_cand;
    logic                  pick_lsb;
    logic                  start;

    // The owner drops its request on seeing done, so its still-high request
    // during the done cycle is ignored; the other side may take the port.
    always_comb begin
        if_cand  = if_req && !(seq_done && (owner == OWNER_IF));
        lsb_cand = lsb_req && !(seq_done && (owner == OWNER_LSB));
        pick_lsb = lsb_cand && (!if_cand || (last_owner == OWNER_IF));
        start    = rdy && !clear && (seq_idle || seq_done) && (if_cand || lsb_cand);
    end

    mem_byte_sequencer #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .en         (rdy),
        .abort      (clear),
        .start      (start),
        .start_we   (pick_lsb && lsb_we),
        .start_size (pick_lsb ? lsb_size : SIZE_W),
        .start_addr (pick_lsb ? lsb_addr : if_addr),
        .start_wdata(pick_lsb ? lsb_wdata : '0),
        .mem_din    (mem_din),
        .idle       (seq_idle),
        .done       (seq_done),
        .fin_read   (fin_read),
        .rdata_next (rdata_next),
        .mem_a      (mem_a),
        .mem_dout   (mem_dout),
        .mem_wr     (mem_wr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= OWNER_IF;
            last_owner <= OWNER_IF;
            if_data    <= '0;
            lsb_rdata  <= '0;
        end else if (rdy) begin
            if (seq_done)
                last_owner <= owner;
            if (start)
                owner <= pick_lsb ? OWNER_LSB : OWNER_IF;
            if (fin_read && (owner == OWNER_IF))
                if_data <= rdata_next;
            if (fin_read && (owner == OWNER_LSB))
                lsb_rdata <= rdata_next;
        end
    end

    assign if_done  = seq_done && (owner == OWNER_IF);
    assign lsb_done = seq_done && (owner == OWNER_LSB);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions plus
// hand-written arbitration, flush and stall sequences, with a done scoreboard.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_req;
    logic        lsb_we;
    logic [1:0]  lsb_size;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          lsb;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
        int          cyc;
        int          stall_at;
        int          stall_len;
        int          clear_at;
    } vec_t;

    typedef struct {
        bit          lsb;
        bit          chk;
        logic [31:0] data;
    } sb_t;

    sb_t  sb_q[$];
    sb_t  mon_e;
    vec_t vecs[18];
    int   alt_cyc[6] = '{2, 8, 11, 17, 20, 26};

    logic [7:0] ram[4096];

    mem_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .clear    (clear),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_data  (if_data),
        .lsb_req  (lsb_req),
        .lsb_we   (lsb_we),
        .lsb_size (lsb_size),
        .lsb_addr (lsb_addr),
        .lsb_wdata(lsb_wdata),
        .lsb_done (lsb_done),
        .lsb_rdata(lsb_rdata),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte RAM with one-cycle registered read, aliased on the low 12 address bits.
    always @(posedge clk) begin
        if (mem_wr)
            ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (if_done || lsb_done)) begin
            if (sb_q.size() == 0) begin
                check_output("unexpected done", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_output("done owner", 32'(lsb_done), 32'(mon_e.lsb));
                check_output("single done", 32'(if_done && lsb_done), 32'd0);
                if (mon_e.chk)
                    check_output("read data", mon_e.lsb ? lsb_rdata : if_data, mon_e.data);
            end
        end
    end

    function automatic vec_t mk(bit lsb, bit we, logic [1:0] size, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] data, int cyc,
                                int sa = -1, int sl = 0, int ca = -1);
        vec_t v;
        v.lsb = lsb; v.we = we; v.size = size; v.addr = addr; v.wdata = wdata;
        v.data = data; v.cyc = cyc; v.stall_at = sa; v.stall_len = sl; v.clear_at = ca;
        return v;
    endfunction

    function automatic sb_t mk_sb(bit lsb, bit chk, logic [31:0] data);
        sb_t e;
        e.lsb = lsb; e.chk = chk; e.data = data;
        return e;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        int n;
        int k;
        int done_cyc;
        bit found;
        n = !v.lsb ? 4 : (v.size == 2'b00) ? 1 : (v.size == 2'b01) ? 2 : 4;
        @(negedge clk);
        sb_q.push_back(mk_sb(v.lsb, !v.we, v.data));
        if (v.lsb) begin
            lsb_req = 1'b1; lsb_we = v.we; lsb_size = v.size;
            lsb_addr = v.addr; lsb_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        k = 0;
        found = 1'b0;
        done_cyc = -1;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (k < n)
                check_output("mem_a", mem_a, v.addr + 32'(k));
            check_output("mem_wr", 32'(mem_wr), 32'(v.we && rdy && (k < n)));
            if (v.we && k < n)
                check_output("mem_dout", 32'(mem_dout), 32'(v.wdata[8*k +: 8]));
            if (v.lsb ? lsb_done : if_done) begin
                found = 1'b1;
                done_cyc = c;
                if_req = 1'b0;
                lsb_req = 1'b0;
            end else begin
                clear = (c == v.clear_at);
                if (c == v.stall_at)
                    rdy = 1'b0;
                else if (v.stall_at >= 0 && c == v.stall_at + v.stall_len)
                    rdy = 1'b1;
                if (rdy)
                    k++;
            end
        end
        if_req = 1'b0;
        lsb_req = 1'b0;
        clear = 1'b0;
        rdy = 1'b1;
        check_output("done cycle", 32'(done_cyc), 32'(v.cyc + v.stall_len));
    endtask

    initial begin
        int nd;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        for (int i = 0; i < 16; i++) ram[12'h200 + i] = 8'h10 + 8'(i);
        ram[12'h100] = 8'h13;

        vecs[0]  = mk(0, 0, 2'b10, 32'h0000_0100, 32'h0, 32'h0000_0013, 5);
        vecs[1]  = mk(0, 0, 2'b10, 32'h0000_0200, 32'h0, 32'h1312_1110, 5);
        vecs[2]  = mk(0, 0, 2'b10, 32'h0000_0203, 32'h0, 32'h1615_1413, 5);
        vecs[3]  = mk(1, 0, 2'b00, 32'h0000_0205, 32'h0, 32'h0000_0015, 2);
        vecs[4]  = mk(1, 0, 2'b01, 32'h0000_0206, 32'h0, 32'h0000_1716, 3);
        vecs[5]  = mk(1, 0, 2'b11, 32'h0000_0208, 32'h0, 32'h1B1A_1918, 5);
        vecs[6]  = mk(1, 1, 2'b01, 32'hFFFF_FFFF, 32'hAABB_CCDD, 32'h0, 2);
        vecs[7]  = mk(1, 0, 2'b01, 32'hFFFF_FFFF, 32'h0, 32'h0000_CCDD, 3);
        vecs[8]  = mk(1, 1, 2'b10, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0, 4);
        vecs[9]  = mk(1, 0, 2'b10, 32'h0000_0300, 32'h0, 32'hDEAD_BEEF, 5);
        vecs[10] = mk(1, 1, 2'b00, 32'h0000_0310, 32'h1234_56A5, 32'h0, 1);
        vecs[11] = mk(1, 0, 2'b10, 32'h0000_0310, 32'h0, 32'h0000_00A5, 5);
        vecs[12] = mk(1, 1, 2'b10, 32'h0000_0330, 32'h4433_2211, 32'h0, 4, -1, 0, 1);
        vecs[13] = mk(1, 0, 2'b10, 32'h0000_0330, 32'h0, 32'h4433_2211, 5);
        vecs[14] = mk(0, 0, 2'b10, 32'h0000_0200, 32'h0, 32'h1312_1110, 5, 3, 3);
        vecs[15] = mk(1, 0, 2'b01, 32'h0000_020E, 32'h0, 32'h0000_1F1E, 3, 2, 2);
        vecs[16] = mk(1, 1, 2'b10, 32'h0000_0340, 32'h8765_4321, 32'h0, 4, 1, 2);
        vecs[17] = mk(1, 0, 2'b10, 32'h0000_0340, 32'h0, 32'h8765_4321, 5);

        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        if_req = 1'b0; if_addr = '0;
        lsb_req = 1'b0; lsb_we = 1'b0; lsb_size = 2'b00; lsb_addr = '0; lsb_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_output("reset mem_a", mem_a, 32'h0);
        check_output("reset mem_wr", 32'(mem_wr), 32'h0);
        check_output("reset mem_dout", 32'(mem_dout), 32'h0);
        check_output("reset if_done", 32'(if_done), 32'h0);
        check_output("reset lsb_done", 32'(lsb_done), 32'h0);
        check_output("reset if_data", if_data, 32'h0);
        check_output("reset lsb_rdata", lsb_rdata, 32'h0);

        // Both requesters held from reset: LSB wins first, then grants alternate.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(mk_sb(1'b1, 1'b1, 32'h0000_0015));
            sb_q.push_back(mk_sb(1'b0, 1'b1, 32'h1312_1110));
        end
        lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 2'b00; lsb_addr = 32'h0000_0205;
        if_req = 1'b1; if_addr = 32'h0000_0200;
        nd = 0;
        for (int c = 0; c < 60 && nd < 6; c++) begin
            @(negedge clk);
            if (if_done || lsb_done) begin
                check_output("alternate done cycle", 32'(c), 32'(alt_cyc[nd]));
                nd++;
            end
        end
        if_req = 1'b0;
        lsb_req = 1'b0;
        check_output("alternate done count", 32'(nd), 32'd6);
        repeat (2) @(negedge clk);
        check_output("idle after alternate", mem_a, 32'h0);

        // Flush during an IF read: abort without a done pulse.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0200;
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        if_req = 1'b0;
        check_output("flush idle addr", mem_a, 32'h0);
        check_output("flush mem_wr", 32'(mem_wr), 32'h0);
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (if_done || lsb_done) nd++;
        end
        check_output("flush no done", 32'(nd), 32'd0);

        for (int i = 0; i < 18; i++)
            apply_stimulus(vecs[i]);

        repeat (2) @(negedge clk);
        check_output("scoreboard empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish by time limit, want finish");
        $fatal(1, "[TB] time limit reached");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and arbitrates the single byte-wide RAM port between instruction fetch (IF) and the load/store buffer (LSB, fed by the load/store reservation station).
- Splits 1/2/4-byte accesses into per-byte RAM cycles and reassembles read data little-endian.
- Returns a one-cycle done pulse to the owning requester.
- Honours the pipeline-wide rdy (freeze) and clear (flush) signals.

Parameters:
- ADDR_WIDTH, 32, width of all byte addresses.
- DATA_WIDTH, 32, width of assembled request data; must be 32.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- rdy  input  1  global enable; low freezes all state.
- clear  input  1  misprediction flush.
- if_req  input  1  IF requests a 4-byte read; level-held until if_done.
- if_addr  input  ADDR_WIDTH  IF fetch address.
- if_done  output  1  one-cycle pulse; if_data valid.
- if_data  output  DATA_WIDTH  fetched word.
- lsb_req  input  1  LSB request; level-held until lsb_done.
- lsb_we  input  1  1 = store, 0 = load.
- lsb_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- lsb_addr  input  ADDR_WIDTH  byte address.
- lsb_wdata  input  DATA_WIDTH  store data; low bytes used.
- lsb_done  output  1  one-cycle pulse; for a load, lsb_rdata valid.
- lsb_rdata  output  DATA_WIDTH  load data, zero-extended; sign extension is done by the LSB.
- mem_din  input  8  RAM read byte; valid one cycle after its address.
- mem_dout  output  8  RAM write byte.
- mem_a  output  ADDR_WIDTH  RAM byte address.
- mem_wr  output  1  RAM write strobe.

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0, last_owner = IF.
- Request latching:
  - States are IDLE, READ and WRITE.
  - In IDLE, on a rising edge with rdy=1, the arbiter selects a requester.
  - It latches addr, size N (IF always 4), wdata and owner.
  - It enters READ, or WRITE for an LSB store.
- Arbitration when both requests are high: the requester that is not last_owner wins. With one request high, that requester wins.
- Cycle numbering: cycle 0 is the first cycle after the accepting edge.
- READ:
  - mem_a = addr+k and mem_wr = 0 during cycle k, for k = 0..N-1.
  - Byte k is sampled from mem_din at the end of cycle k+1 into bits [8k+7:8k].
  - Done for the owner is high during cycle N+1, with data valid. Load latency is N+1 cycles.
  - Upper unfilled bytes are 0.
- WRITE:
  - mem_wr = 1, mem_a = addr+k and mem_dout = wdata[8k+7:8k] during cycle k.
  - lsb_done is high during cycle N.
  - mem_wr = 0 outside WRITE.
- Address increment is modulo 2^ADDR_WIDTH; wrap-around is legal.
- Return to IDLE occurs on the edge that ends the done cycle. The owner's req is ignored during its done cycle, because requesters drop req on seeing done. The other requester may be accepted at that edge.
- last_owner updates when a transaction completes.
- Back-to-back throughput: a new request is accepted at the edge ending the previous done cycle.
- clear=1 (sampled with rdy=1):
  - Aborts IF reads and LSB loads, in progress or pending: go to IDLE with no done pulse, and force mem_wr to 0 next cycle.
  - A WRITE in progress continues to completion and pulses lsb_done, because stores are committed, non-speculative work.
  - Requests held during the clear cycle are not accepted that cycle.
- rdy=0: no state, counter or output register changes; mem_wr is forced 0 combinationally; the RAM sees a repeated address, which is harmless for reads. On rdy returning to 1, the sequence resumes from the same byte.
- rst has priority over clear; clear has priority over new acceptance.
- mem_a in IDLE holds 0.
- if_data and lsb_rdata hold their last value outside done cycles.

Decomposition:
- Shared definitions header gains:
  - state encodings MEM_IDLE/MEM_READ/MEM_WRITE;
  - size encodings SIZE_B/SIZE_H/SIZE_W;
  - owner encodings OWNER_IF/OWNER_LSB;
  - the existing Enable/Disable/Valid/Null macros.
- Natural sub-module: mem_byte_sequencer. It holds the counter, address increment, byte shift-in/out and the done generation. The arbiter top holds request selection, ownership and the clear/rdy policy.

Test Plan:
- IF-only read, if_addr=0x100, RAM[0x100..0x103]=13 00 00 00:
  - mem_a steps 0x100..0x103 over cycles 0-3.
  - if_done is high in cycle 5 with if_data=0x00000013.
- LSB store, size=01, addr=0x0FFFFFFFF wrap, wdata=0xAABBCCDD:
  - cycle 0: mem_wr=1, addr 0xFFFFFFFF, dout DD.
  - cycle 1: addr 0x00000000, dout CC.
  - lsb_done is high in cycle 2.
- Simultaneous if_req and lsb_req from reset (last_owner=IF):
  - LSB byte load is granted first; lsb_done is high in cycle 2.
  - IF is accepted at the edge ending cycle 2.
  - Repeat with both requests held continuously: grants alternate.
- clear asserted in cycle 2 of an IF read: no if_done, return to IDLE. clear asserted during a word store: all 4 bytes are written and lsb_done pulses.
- rdy low for 3 cycles mid-read, after byte 1:
  - mem_wr stays 0 and the counter is frozen.
  - The assembled data equals the no-stall result.
  - done is delayed by exactly 3 cycles.
